// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the TLC549-class serial ADC front-end.
//   - adc_state_e : acquisition FSM states
//   - ADC_BITS    : sample width
//   - *_DEF       : default timing constants (50 MHz system clock), also used
//                   by the downstream averaging stage
//   - max3        : helper for sizing the shared timing counter
package adc_pkg;

  localparam int ADC_BITS = 8;

  localparam int CLK_DIV_DEF   = 25;    // 1 MHz io_clk from 50 MHz
  localparam int CS_SETUP_DEF  = 70;    // 1.4 us
  localparam int CONV_WAIT_DEF = 1000;  // 20 us conversion gap

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    CONV
  } adc_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous input bit.
//   clk : destination clock
//   rst : asynchronous active-high reset, both stages clear to 0
//   d   : asynchronous input
//   q   : synchronized output (two clk cycles of latency)
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/adc_sam.sv
// adc_sam: serial front-end for an 8-bit TLC549-class ADC.
// Runs back-to-back frames while en is high: cs_n low, CS_SETUP wait,
// eight io_clk periods (MSB first, sampled on each io_clk rise), a one-cycle
// DONE that publishes the byte, then a CONV_WAIT gap with cs_n high.
//   s_clk      : system clock
//   s_rst      : asynchronous active-high reset
//   en         : level-sensitive enable for free-running acquisition
//   adc_sdo    : ADC serial data, asynchronous to s_clk
//   adc_cs_n   : ADC chip select, active low (registered)
//   adc_io_clk : ADC I/O clock (registered)
//   dout       : last complete sample, held until the next frame completes
//   sam_end    : one-cycle strobe marking a dout update
module adc_sam
  import adc_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int CS_SETUP  = CS_SETUP_DEF,
  parameter int CONV_WAIT = CONV_WAIT_DEF
) (
  input  logic                s_clk,
  input  logic                s_rst,
  input  logic                en,
  input  logic                adc_sdo,
  output logic                adc_cs_n,
  output logic                adc_io_clk,
  output logic [ADC_BITS-1:0] dout,
  output logic                sam_end
);

  localparam int CNT_W = $clog2(max3(CLK_DIV, CS_SETUP, CONV_WAIT) + 1);
  localparam int BIT_W = $clog2(ADC_BITS);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_WAIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(ADC_BITS - 1);

  adc_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ADC_BITS-1:0] shift_q, shift_d;
  logic [ADC_BITS-1:0] dout_q, dout_d;
  logic                cs_n_q, cs_n_d;
  logic                io_clk_q, io_clk_d;
  logic                sam_end_q, sam_end_d;
  logic                sdo_s;

  sync2 u_sdo_sync (
    .clk (s_clk),
    .rst (s_rst),
    .d   (adc_sdo),
    .q   (sdo_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    dout_d    = dout_q;
    cs_n_d    = cs_n_q;
    io_clk_d  = io_clk_q;
    sam_end_d = 1'b0;

    case (state_q)
      IDLE: begin
        cs_n_d   = 1'b1;
        io_clk_d = 1'b0;
        cnt_d    = '0;
        if (en) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
        end
      end

      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d    = '0;
          io_clk_d = 1'b0;
          state_d  = SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!io_clk_q) begin
            // End of low phase: the bit launched on the previous fall has
            // had CLK_DIV cycles to clear the synchronizer.
            io_clk_d = 1'b1;
            shift_d  = {shift_q[ADC_BITS-2:0], sdo_s};
          end else begin
            io_clk_d = 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              cs_n_d    = 1'b1;
              state_d   = DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        dout_d    = shift_q;
        sam_end_d = 1'b1;
        cnt_d     = '0;
        state_d   = CONV;
      end

      CONV: begin
        // en is only looked at when the gap has fully elapsed, so an early
        // re-enable can never shorten the conversion time.
        if (cnt_q == CONV_LAST) begin
          cnt_d = '0;
          if (en) begin
            state_d = SETUP;
            cs_n_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        cs_n_d   = 1'b1;
        io_clk_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      cs_n_q    <= 1'b1;
      io_clk_q  <= 1'b0;
      sam_end_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      cs_n_q    <= cs_n_d;
      io_clk_q  <= io_clk_d;
      sam_end_q <= sam_end_d;
    end
  end

  assign adc_cs_n   = cs_n_q;
  assign adc_io_clk = io_clk_q;
  assign dout       = dout_q;
  assign sam_end    = sam_end_q;

endmodule
